// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: bundles the instruction-memory read handshake and the
// downstream instruction valid/ready handshake of the fetch controller.
//   master : the fetch controller side (drives req/addr, valid/inst/pc)
//   slave  : memory + decode side (drives ack/rdata, ready)
interface ifetch_ctrl_if;
  localparam int unsigned XLEN = 32;

  // instruction memory read port
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  // downstream instruction port
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_out;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller sitting between the PC register,
// instruction memory and decode. Per instruction it samples the PC, fetches
// one word over req/ack, offers it downstream over valid/ready, then loads
// the next PC (sequential or redirected) back into the PC register.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc_in             current PC from the PC register output
//   pc_ena, pc_next   load enable / load value to the PC register
//   br_valid/target   redirect request and its target PC
//   stall             holds off the start of a new fetch
//   fault             sticky error (misaligned PC or memory timeout)
//   bus               memory and downstream handshakes (master side)
module ifetch_ctrl #(
  parameter logic [31:0] STEP    = 32'd4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_in,
  output logic                pc_ena,
  output logic [31:0]         pc_next,
  input  logic                br_valid,
  input  logic [31:0]         br_target,
  input  logic                stall,
  output logic                fault,
  ifetch_ctrl_if.master       bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);
  // counter value during the last request cycle that may still be acked
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_UPDATE,
    S_FAULT
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] ipc_q;
  logic [XLEN-1:0] pc_next_q;
  logic [XLEN-1:0] br_tgt_q;
  logic            br_pend_q;
  logic [TW-1:0]   to_cnt_q;

  logic            br_take;
  logic [XLEN-1:0] pc_next_d;

  // Redirects are only observed while an instruction is in flight.
  assign br_take = br_valid &&
                   ((state_q == S_IDLE) || (state_q == S_FETCH) || (state_q == S_HOLD));

  // A same-cycle redirect beats an older pending one; otherwise step on.
  assign pc_next_d = br_valid  ? br_target :
                     br_pend_q ? br_tgt_q  :
                                 ipc_q + STEP;

  // Fetch sequencer and all data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      inst_q    <= '0;
      ipc_q     <= '0;
      pc_next_q <= '0;
      br_tgt_q  <= '0;
      br_pend_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      if (br_take) begin
        br_pend_q <= 1'b1;
        br_tgt_q  <= br_target;
      end

      case (state_q)
        S_IDLE: begin
          if (!stall) begin
            if (pc_in[1:0] != 2'b00) begin
              state_q <= S_FAULT;
            end else begin
              addr_q   <= pc_in;
              to_cnt_q <= '0;
              state_q  <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (bus.imem_ack) begin
            inst_q  <= bus.imem_rdata;
            ipc_q   <= addr_q;
            state_q <= S_HOLD;
          end else if (to_cnt_q == TO_LAST) begin
            state_q <= S_FAULT;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end

        S_HOLD: begin
          if (bus.inst_ready) begin
            pc_next_q <= pc_next_d;
            // consuming the redirect overrides any set from this cycle
            br_pend_q <= 1'b0;
            state_q   <= S_UPDATE;
          end
        end

        S_UPDATE: state_q <= S_IDLE;

        S_FAULT:  state_q <= S_FAULT;

        default:  state_q <= S_FAULT;
      endcase
    end
  end

  // Control strobes decode straight from the state register.
  assign bus.imem_req   = (state_q == S_FETCH);
  assign bus.inst_valid = (state_q == S_HOLD);
  assign pc_ena         = (state_q == S_UPDATE);
  assign fault          = (state_q == S_FAULT);

  assign bus.imem_addr  = addr_q;
  assign bus.inst_out   = inst_q;
  assign bus.inst_pc    = ipc_q;
  assign pc_next        = pc_next_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: randomized plus directed bench for ifetch_ctrl. The bench
// models the PC register, a latency-configurable memory and the decode side,
// and predicts every fetch address, instruction and next PC at transaction
// level (one instruction per pc_ena pulse).
module tb_ifetch_ctrl;
  localparam logic [31:0] STEP    = 32'd4;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        br_valid;
  logic [31:0] br_target;
  logic        stall;
  logic        fault;

  ifetch_ctrl_if bus();

  ifetch_ctrl #(.STEP(STEP), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_ena    (pc_ena),
    .pc_next   (pc_next),
    .br_valid  (br_valid),
    .br_target (br_target),
    .stall     (stall),
    .fault     (fault),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // reference state
  logic [31:0] pc_model;
  logic        br_pend_m;
  logic [31:0] br_tgt_m;
  logic        req_prev, ena_prev;
  int          cycle_n, last_ena, cadence;

  // environment knobs
  int unsigned ack_min, ack_max, rdy_min, rdy_max, br_pct, stall_pct;
  logic        ack_never, ack_noise, junk_ack, stall_force, force_br;
  logic [31:0] force_tgt;
  int unsigned ack_wait, rdy_wait;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Compare DUT outputs against the transaction-level prediction.
  task automatic monitor();
    logic [31:0] exp_next;
    if (bus.imem_req && !req_prev) check("imem_addr", bus.imem_addr, pc_model);
    if (bus.inst_valid) begin
      check("inst_pc", bus.inst_pc, pc_model);
      check("inst_out", bus.inst_out, mem_word(pc_model));
      check("pc_ena_in_hold", 32'(pc_ena), 32'd0);
    end
    if (pc_ena) begin
      exp_next = br_pend_m ? br_tgt_m : pc_model + STEP;
      check("pc_next", pc_next, exp_next);
      check("pc_ena_width", 32'(ena_prev), 32'd0);
      check("fault_run", 32'(fault), 32'd0);
      pc_model  = exp_next;
      br_pend_m = 1'b0;
      cadence   = cycle_n - last_ena;
      last_ena  = cycle_n;
    end
    req_prev = bus.imem_req;
    ena_prev = pc_ena;
  endtask

  // Drive PC register, memory, decode and redirect inputs for the next edge.
  task automatic drive();
    pc_in = pc_model;
    if (bus.imem_req && !ack_never) begin
      if (ack_wait == 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
      end else begin
        ack_wait--;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
      end
    end else begin
      ack_wait       = $urandom_range(ack_max, ack_min);
      bus.imem_ack   = junk_ack || (ack_noise && !bus.imem_req && ($urandom_range(1, 0) == 1));
      bus.imem_rdata = $urandom;
    end

    if (bus.inst_valid) begin
      if (rdy_wait == 0) bus.inst_ready = 1'b1;
      else begin
        rdy_wait--;
        bus.inst_ready = 1'b0;
      end
    end else begin
      rdy_wait       = $urandom_range(rdy_max, rdy_min);
      bus.inst_ready = 1'($urandom_range(1, 0));
    end

    stall     = stall_force || ($urandom_range(99, 0) < stall_pct);
    br_valid  = 1'b0;
    br_target = $urandom & 32'hFFFF_FFFC;
    if (force_br && bus.imem_req) begin
      br_valid  = 1'b1;
      br_target = force_tgt;
      force_br  = 1'b0;
    end else if ($urandom_range(99, 0) < br_pct) begin
      br_valid = 1'b1;
    end
    // a redirect counts while an instruction is in flight (not UPDATE/fault)
    if (br_valid && !pc_ena && !fault && !rst) begin
      br_pend_m = 1'b1;
      br_tgt_m  = br_target;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cycle_n++;
    monitor();
    drive();
  endtask

  task automatic do_reset(input int cycles, input logic [31:0] pc);
    rst       = 1'b1;
    pc_model  = pc;
    pc_in     = pc;
    br_pend_m = 1'b0;
    repeat (cycles) cyc();
    check("rst_pc_ena", 32'(pc_ena), 32'd0);
    check("rst_pc_next", pc_next, 32'd0);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst_out", bus.inst_out, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst       = 1'b0;
    br_valid  = 1'b0;
    br_pend_m = 1'b0;
  endtask

  task automatic run_until_ena(input string tag, input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      cyc();
      if (pc_ena) got = 1;
    end
    check(tag, 32'(got), 32'd1);
  endtask

  initial begin
    int          cnt, flt, seen;
    logic [31:0] p;
    rst = 1'b1; pc_in = '0; br_valid = 1'b0; br_target = '0; stall = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    pc_model = '0; br_pend_m = 1'b0; br_tgt_m = '0;
    req_prev = 1'b0; ena_prev = 1'b0; cycle_n = 0; last_ena = 0; cadence = 0;
    ack_min = 0; ack_max = 0; rdy_min = 0; rdy_max = 0; br_pct = 0; stall_pct = 0;
    ack_never = 1'b0; ack_noise = 1'b0; junk_ack = 1'b0; stall_force = 1'b0;
    force_br = 1'b0; force_tgt = '0; ack_wait = 0; rdy_wait = 0;

    // aligned fetch, immediate handshakes, 4-cycle cadence
    do_reset(2, 32'h0040_0000);
    run_until_ena("t1_ena", 20);
    check("t1_pc_next", pc_next, 32'h0040_0004);
    run_until_ena("t1_ena2", 20);
    run_until_ena("t1_ena3", 20);
    check("t1_cadence", 32'(cadence), 32'd4);

    // stall holds IDLE
    stall_force = 1'b1;
    seen = 0;
    repeat (6) begin
      cyc();
      if (bus.imem_req) seen = 1;
    end
    check("t1_stall_no_req", 32'(seen), 32'd0);
    stall_force = 1'b0;
    run_until_ena("t1_after_stall", 20);

    // redirect during FETCH, then sequential
    ack_min = 2; ack_max = 2;
    force_br = 1'b1; force_tgt = 32'h0040_0100;
    run_until_ena("t2_ena", 20);
    check("t2_pc_next", pc_next, 32'h0040_0100);
    run_until_ena("t2_ena2", 20);
    check("t2_seq", pc_next, 32'h0040_0104);
    ack_min = 0; ack_max = 0;

    // wrap-around
    do_reset(1, 32'hFFFF_FFFC);
    run_until_ena("t3_ena", 20);
    check("t3_wrap", pc_next, 32'h0000_0000);
    run_until_ena("t3_ena2", 20);

    // randomized traffic
    do_reset(2, $urandom & 32'hFFFF_FFFC);
    ack_min = 0; ack_max = 4; rdy_min = 0; rdy_max = 4;
    br_pct = 10; stall_pct = 20; ack_noise = 1'b1;
    for (int n = 0; n < 150; n++) run_until_ena("rnd_ena", 80);
    ack_max = 0; rdy_max = 0; br_pct = 0; stall_pct = 0; ack_noise = 1'b0;

    // misaligned PC faults and sticks
    do_reset(2, 32'h0040_0002);
    cyc();
    check("t4_fault_rise", 32'(fault), 32'd1);
    seen = 0;
    repeat (10) begin
      cyc();
      if (bus.imem_req || bus.inst_valid || pc_ena) seen = 1;
    end
    check("t4_no_activity", 32'(seen), 32'd0);
    check("t4_fault_sticky", 32'(fault), 32'd1);
    do_reset(1, 32'h0040_0000);

    // timeout after 16 unacked request cycles
    ack_never = 1'b1;
    do_reset(1, 32'h0040_0000);
    cnt = 0; flt = 0;
    for (int i = 0; i < 40 && flt == 0; i++) begin
      cyc();
      if (bus.imem_req) cnt++;
      if (fault) flt = 1;
    end
    check("t5_req_cycles", 32'(cnt), 32'd16);
    check("t5_fault", 32'(fault), 32'd1);
    check("t5_req_low", 32'(bus.imem_req), 32'd0);
    ack_never = 1'b0;

    // ack in the 16th cycle is accepted
    ack_min = 15; ack_max = 15;
    do_reset(1, 32'h0040_0000);
    run_until_ena("t5b_ena", 40);
    check("t5b_no_fault", 32'(fault), 32'd0);
    ack_min = 0; ack_max = 0;

    // backpressure: ready low for 5 valid cycles
    rdy_min = 5; rdy_max = 5;
    do_reset(1, 32'h0040_0200);
    cnt = 0; flt = 0;
    for (int i = 0; i < 30 && flt == 0; i++) begin
      cyc();
      if (bus.inst_valid) cnt++;
      if (pc_ena) flt = 1;
    end
    check("t6_valid_cycles", 32'(cnt), 32'd6);
    check("t6_ena_seen", 32'(flt), 32'd1);

    // reset during HOLD, restart from current PC
    rdy_min = 100; rdy_max = 100;
    for (int i = 0; i < 20 && !bus.inst_valid; i++) cyc();
    check("t6_in_hold", 32'(bus.inst_valid), 32'd1);
    p = pc_model;
    do_reset(1, p);
    rdy_min = 0; rdy_max = 0;
    run_until_ena("t6_hold_restart", 20);
    check("t6_hold_pc_next", pc_next, p + 32'd4);

    // reset during FETCH, late ack while stalled is ignored
    ack_min = 3; ack_max = 3;
    for (int i = 0; i < 20 && !bus.imem_req; i++) cyc();
    check("t6_in_fetch", 32'(bus.imem_req), 32'd1);
    p = pc_model;
    stall_force = 1'b1; junk_ack = 1'b1;
    do_reset(1, p);
    repeat (3) begin
      cyc();
      check("t6_late_ack_req", 32'(bus.imem_req), 32'd0);
      check("t6_late_ack_valid", 32'(bus.inst_valid), 32'd0);
    end
    stall_force = 1'b0; junk_ack = 1'b0;
    run_until_ena("t6_fetch_restart", 20);
    check("t6_fetch_pc_next", pc_next, p + 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
